// File: rtl/uart_rx_frame_if.sv
// Port group of the UART RX frame decoder: serial line and frame format in, word and status strobes out.
// The decoder side uses the slave modport; the line/format driver and the word consumer use master.
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stop_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stop_err
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART RX frame decoder: start detect, centre sampling, parity/stop check, parallel word out.
// Latency: outcome strobe in cycle N*Prescale after start detection (N = frame bits), all outputs registered.
// Backpressure: none; the serial line cannot be stalled, every outcome is a one-cycle strobe.
// Optional UART_RX_MAJ_VOTE_EN: each bit is the 2-of-3 vote of samples around the bit centre.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_frame_if.slave rx
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_nxt;
    logic [5:0]            edge_cnt;
    logic [5:0]            pre_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bad;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic [5:0]            half;
    logic                  bit_end;
    logic                  bit_val;

    assign half    = pre_q >> 1;
    assign bit_end = (edge_cnt == pre_q - 6'd1);

`ifdef UART_RX_MAJ_VOTE_EN
    logic [2:0] samp;
    assign bit_val = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
`else
    logic samp;
    assign bit_val = samp;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rx.RX_IN) state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (bit_end && bit_cnt == LAST_BIT) state_nxt = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            // A low line in the following IDLE cycle is edge 0 of the next start bit.
            S_STOP:   if (bit_end) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_cnt     <= '0;
            pre_q        <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bad      <= 1'b0;
            samp         <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            if (state == S_IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                par_bad  <= 1'b0;
                if (!rx.RX_IN) begin
                    // Frame format is frozen for the whole frame from this cycle on.
                    edge_cnt  <= 6'd1;
                    pre_q     <= rx.Prescale;
                    par_en_q  <= rx.PAR_EN;
                    par_typ_q <= rx.PAR_TYP;
                end
            end else begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
`ifdef UART_RX_MAJ_VOTE_EN
                if (edge_cnt == half - 6'd1 || edge_cnt == half || edge_cnt == half + 6'd1)
                    samp <= {samp[1:0], rx.RX_IN};
`else
                if (edge_cnt == half)
                    samp <= rx.RX_IN;
`endif
                if (bit_end) begin
                    case (state)
                        S_DATA: begin
                            shreg[DATA_WIDTH-1] <= bit_val;
                            for (int i = 0; i < DATA_WIDTH - 1; i++)
                                shreg[i] <= shreg[i+1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        S_PARITY: par_bad <= (bit_val != (^shreg ^ par_typ_q));
                        S_STOP: begin
                            if (bit_val && !par_bad) begin
                                data_valid_q <= 1'b1;
                                p_data_q     <= shreg;
                            end
                            par_err_q  <= par_bad;
                            stop_err_q <= ~bit_val;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign rx.P_DATA     = p_data_q;
    assign rx.data_valid = data_valid_q;
    assign rx.par_err    = par_err_q;
    assign rx.stop_err   = stop_err_q;
endmodule
